// File: rtl/instr_fetch_dispatch_pkg.sv
// Shared ISA constants and controller state encoding for the instruction fetch/dispatch block.
package instr_fetch_dispatch_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_MOVI = 4'h7;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_DECODE   = 3'd3,
    ST_EXEC     = 3'd4,
    ST_HALT     = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

endpackage

// File: rtl/instr_fetch_dispatch_exec_watchdog.sv
// Execution timeout: down-counter loaded on clear, expired once TIMEOUT enabled cycles have elapsed.
module exec_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= CW'(TIMEOUT);
    end else if (clear) begin
      count <= CW'(TIMEOUT);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch/dispatch controller: fetches words at pc, runs NOP/HALT locally and hands
// everything else to the execution FSMs via instr_out/exec_start, tracking their PC_inc and done.
//
// state    | meaning
// IDLE     | stopped at an instruction boundary, waiting for run
// FETCH    | imem_rd asserted with imem_addr = pc
// WAIT_MEM | memory data returns; latched into instr_out at cycle end
// DECODE   | NOP advances pc, HALT stops, others dispatch
// EXEC     | execution FSM running; counts PC_inc, waits for done
// HALT     | absorbing after HALT opcode
// FAULT    | absorbing after execution timeout
module instr_fetch_dispatch
  import instr_fetch_dispatch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               exec_start,
  input  logic               exec_pc_inc,
  input  logic               exec_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fault
);

  state_t             state;
  logic               inc_seen;
  logic               wd_expired;
  logic [OPC_W-1:0]   opcode;
  logic [ADDR_W-1:0]  pc_inc1;
  logic [ADDR_W-1:0]  pc_exec;

  assign opcode  = instr_out[INSTR_W-1 -: OPC_W];
  assign pc_inc1 = pc + ADDR_W'(1);

  // A done with no PC_inc seen during the whole instruction implies a single-word advance.
  always_comb begin
    pc_exec = pc;
    if (exec_pc_inc || (exec_done && !inc_seen)) pc_exec = pc_inc1;
  end

  exec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_DECODE),
    .enable  (state == ST_EXEC),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      instr_out  <= '0;
      imem_addr  <= '0;
      imem_rd    <= 1'b0;
      exec_start <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      inc_seen   <= 1'b0;
    end else begin
      imem_rd    <= 1'b0;
      exec_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state     <= ST_FETCH;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_FETCH: state <= ST_WAIT_MEM;
        ST_WAIT_MEM: begin
          instr_out <= imem_rdata;
          state     <= ST_DECODE;
        end
        ST_DECODE: begin
          if (opcode == OPC_NOP) begin
            pc <= pc_inc1;
            if (run) begin
              state     <= ST_FETCH;
              imem_rd   <= 1'b1;
              imem_addr <= pc_inc1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (opcode == OPC_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state      <= ST_EXEC;
            exec_start <= 1'b1;
            inc_seen   <= 1'b0;
          end
        end
        ST_EXEC: begin
          pc <= pc_exec;
          if (exec_pc_inc) inc_seen <= 1'b1;
          // done in the final watchdog cycle still wins over the timeout
          if (exec_done) begin
            if (run) begin
              state     <= ST_FETCH;
              imem_rd   <= 1'b1;
              imem_addr <= pc_exec;
            end else begin
              state <= ST_IDLE;
            end
          end else if (wd_expired) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end
        end
        ST_HALT:  ;
        ST_FAULT: ;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Directed bench for instr_fetch_dispatch with a 1-cycle imem model and a programmable execution stub.
module tb_instr_fetch_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr_out;
  logic        exec_start;
  logic        exec_pc_inc;
  logic        exec_done;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;

  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  // execution stub: cycle k=0 is the exec_start cycle
  int          cnt;
  int          stub_k;
  logic        stub_active;
  int          done_k = -1;
  logic [31:0] inc_mask = '0;
  int          start_cnt;
  int          rd_cnt;

  instr_fetch_dispatch #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .exec_start  (exec_start),
    .exec_pc_inc (exec_pc_inc),
    .exec_done   (exec_done),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  always_comb begin
    stub_k      = exec_start ? 0 : cnt;
    stub_active = exec_start || (cnt != 0);
    exec_pc_inc = stub_active && (stub_k < 32) && inc_mask[stub_k];
    exec_done   = stub_active && (stub_k == done_k);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 0;
      start_cnt <= 0;
      rd_cnt    <= 0;
    end else begin
      if (exec_start) start_cnt <= start_cnt + 1;
      if (imem_rd) rd_cnt <= rd_cnt + 1;
      if (stub_active) cnt <= (stub_k == done_k) ? 0 : stub_k + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 50 && exec_start !== 1'b1; i++) tick();
    check(tag, exec_start, 1);
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 100 && halted !== 1'b1; i++) tick();
    check(tag, halted, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    run      = 1'b0;
    inc_mask = '0;
    done_k   = -1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #2 rst = 1'b0;
    ticks(2);
    check("rst_pc", pc, 0);
    check("rst_instr", instr_out, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_rd", imem_rd, 0);
    check("rst_start", exec_start, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);

    // 1: MOVI dispatch, one inc at k=1, done at k=2
    do_reset();
    mem[0] = 16'h7002; mem[1] = 16'hF000;
    inc_mask = 32'h2; done_k = 2;
    run = 1'b1;
    tick();
    check("t1_fetch_rd", imem_rd, 1);
    check("t1_fetch_addr", imem_addr, 0);
    ticks(2);
    check("t1_instr", instr_out, 16'h7002);
    check("t1_no_early_start", exec_start, 0);
    tick();
    check("t1_start_cycle4", exec_start, 1);
    check("t1_pc_before_inc", pc, 0);
    tick();
    check("t1_start_pulse", exec_start, 0);
    tick();
    check("t1_pc_after_inc", pc, 1);
    tick();
    check("t1_next_fetch_rd", imem_rd, 1);
    check("t1_next_fetch_addr", imem_addr, 1);
    check("t1_pc_no_implicit", pc, 1);
    wait_halted("t1_halt");
    check("t1_pc_final", pc, 1);
    check("t1_start_count", start_cnt, 1);

    // 2: NOP then HALT
    do_reset();
    mem[0] = 16'h0000; mem[1] = 16'hF000;
    run = 1'b1;
    ticks(4);
    check("t2_nop_pc", pc, 1);
    check("t2_nop_fetch_addr", imem_addr, 1);
    check("t2_nop_fetch_rd", imem_rd, 1);
    ticks(3);
    check("t2_halted", halted, 1);
    check("t2_halt_pc", pc, 1);
    run = 1'b0;
    ticks(3);
    run = 1'b1;
    ticks(3);
    check("t2_still_halted", halted, 1);
    check("t2_pc_held", pc, 1);
    check("t2_no_start", start_cnt, 0);
    check("t2_fetches", rd_cnt, 2);
    check("t2_instr_held", instr_out, 16'hF000);

    // 3a: done without inc -> implicit advance
    do_reset();
    mem[0] = 16'h7000; mem[1] = 16'hF000;
    done_k = 1;
    run = 1'b1;
    wait_halted("t3a_halt");
    check("t3a_pc", pc, 1);

    // 3b: incs at k=1,2 and inc+done at k=3 -> pc+=3
    do_reset();
    mem[0] = 16'h7005; mem[3] = 16'hF000;
    inc_mask = 32'hE; done_k = 3;
    run = 1'b1;
    wait_halted("t3b_halt");
    check("t3b_pc", pc, 3);
    check("t3b_instr", instr_out, 16'hF000);

    // 3c: inc and done both in the exec_start cycle -> pc+=1 only
    do_reset();
    mem[0] = 16'h7001; mem[1] = 16'hF000;
    inc_mask = 32'h1; done_k = 0;
    run = 1'b1;
    wait_halted("t3c_halt");
    check("t3c_pc", pc, 1);

    // 4: no done -> fault on the 16th cycle after exec_start
    do_reset();
    mem[0] = 16'h7001;
    inc_mask = 32'h4; done_k = -1;
    run = 1'b1;
    wait_start("t4_start");
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("t4_no_fault_c%0d", i), fault, 0);
    end
    tick();
    check("t4_fault_c16", fault, 1);
    check("t4_fault_pc", pc, 1);
    check("t4_not_halted", halted, 0);
    ticks(5);
    check("t4_no_rd", imem_rd, 0);
    check("t4_single_fetch", rd_cnt, 1);
    check("t4_fault_sticky", fault, 1);

    // 5: NOP run to 0xFF, wrap to 0, then stop mid-EXEC
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 1000 && pc !== 8'hFF; i++) tick();
    check("t5_pc_ff", pc, 8'hFF);
    check("t5_addr_ff", imem_addr, 8'hFF);
    mem[0] = 16'h7000; done_k = 3;
    ticks(3);
    check("t5_pc_wrap", pc, 0);
    check("t5_addr_wrap", imem_addr, 0);
    check("t5_rd_wrap", imem_rd, 1);
    ticks(3);
    check("t5_start", exec_start, 1);
    run = 1'b0;
    ticks(4);
    check("t5_pc_after", pc, 1);
    check("t5_fetches", rd_cnt, 257);
    ticks(10);
    check("t5_no_more_fetch", rd_cnt, 257);
    check("t5_rd_low", imem_rd, 0);

    // 6: async reset mid-EXEC
    do_reset();
    mem[0] = 16'h7002;
    inc_mask = 32'h2; done_k = -1;
    run = 1'b1;
    wait_start("t6_start");
    ticks(2);
    check("t6_pc_pre", pc, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_pc", pc, 0);
    check("t6_instr", instr_out, 0);
    check("t6_addr", imem_addr, 0);
    check("t6_rd", imem_rd, 0);
    check("t6_start", exec_start, 0);
    check("t6_halted", halted, 0);
    check("t6_fault", fault, 0);
    run = 1'b0;
    mem[0] = 16'hF000;
    @(negedge clk);
    rst = 1'b1;
    tick();
    run = 1'b1;
    tick();
    check("t6_restart_rd", imem_rd, 1);
    check("t6_restart_addr", imem_addr, 0);
    wait_halted("t6_halt");
    check("t6_halt_pc", pc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
